// File: rtl/fetch_controller.sv
// fetch_controller
//   Drives the instruction-memory PC, tracks the single outstanding read and
//   buffers returned instructions in a DEPTH-entry FIFO toward decode.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   imem_pc        PC presented to instruction memory (combinational from pc_q)
//   imem_instr     instruction returned the cycle after issue
//   imem_stop      end-of-program flag, qualifies imem_instr
//   redirect_valid flush queue and restart fetch at redirect_pc
//   redirect_pc    new fetch PC (low two bits ignored)
//   out_valid      queue head valid
//   out_instr      queue head instruction
//   out_pc         PC of the queue head instruction
//   out_ready      decode accepts head when out_valid && out_ready
//   queue_count    entries currently held
//   fetch_done     halted on stop and queue drained
module fetch_controller #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_pc,
  input  logic [31:0]                imem_instr,
  input  logic                       imem_stop,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       fetch_done
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StFetch, StHalt} state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic        inflight_v_q, inflight_v_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic [31:0]     q_instr_q [DEPTH];
  logic [31:0]     q_pc_q    [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic            issue;
  logic            push;
  logic            pop;
  logic            ret_stop;
  logic            credit_ok;
  logic [CntW:0]   credit;

  // ---------------------------------------------------------------------------
  // Handshake and return qualification
  // ---------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign ret_stop  = inflight_v_q && imem_stop;
  // A redirect drops the returning instruction and ignores any pop.
  assign push      = inflight_v_q && !imem_stop && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

  // Credit counts the in-flight read so a return always finds a free slot.
  assign credit    = {1'b0, count_q} + {{CntW{1'b0}}, inflight_v_q};
  assign credit_ok = credit < (CntW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StFetch;
    end else if (ret_stop) begin
      state_d = StHalt;
    end
  end

  // FSM: outputs
  always_comb begin
    issue      = (state_q == StFetch) && !redirect_valid && credit_ok;
    fetch_done = (state_q == StHalt) && (count_q == '0);
  end

  // ---------------------------------------------------------------------------
  // PC and in-flight tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (ret_stop) begin
      // Squash any read issued this cycle and resume from the stopped PC.
      pc_d = inflight_pc_q;
    end else if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_v_d  = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign imem_pc = pc_q;

  // ---------------------------------------------------------------------------
  // Fetch queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // Clearing storage makes out_instr/out_pc read zero straight out of reset.
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        q_instr_q[wr_ptr_q] <= imem_instr;
        q_pc_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pushing into a full queue without a matching pop would lose data.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) begin
      assert (count_q != CntW'(DEPTH));
    end
  end

  assign out_instr   = q_instr_q[rd_ptr_q];
  assign out_pc      = q_pc_q[rd_ptr_q];
  assign queue_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        imem_stop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [2:0]  queue_count;
  logic        fetch_done;

  fetch_controller #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .imem_stop      (imem_stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .queue_count    (queue_count),
    .fetch_done     (fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 1-cycle registered read, instr = PC*16.
  logic        stop_en;
  logic [31:0] stop_pc;
  always @(posedge clk) begin
    imem_instr <= imem_pc << 4;
    imem_stop  <= stop_en && (imem_pc == stop_pc);
  end

  int          nchecks;
  int          nerr;
  int          hs_cnt;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [2:0]  cnt;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle; a handshake here means the head leaves at the next edge.
  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL sb_unexpected: got pc %0h expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, e << 4);
      end
    end
  endtask

  task automatic fill(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stop_en        = 1'b0;
    stop_pc        = '0;
    tick();
    tick();
    exp_q.delete();
    hs_cnt = 0;
    rst    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nchecks = 0;
    nerr    = 0;
    hs_cnt  = 0;

    // Backpressure table: {out_ready, out_valid, queue_count, imem_pc} per cycle.
    tbl[0]  = '{1'b0, 1'b0, 3'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 32'd4};
    tbl[2]  = '{1'b0, 1'b1, 3'd1, 32'd8};
    tbl[3]  = '{1'b0, 1'b1, 3'd2, 32'd12};
    tbl[4]  = '{1'b0, 1'b1, 3'd3, 32'd16};
    tbl[5]  = '{1'b0, 1'b1, 3'd4, 32'd16};
    tbl[6]  = '{1'b0, 1'b1, 3'd4, 32'd16};
    tbl[7]  = '{1'b0, 1'b1, 3'd4, 32'd16};
    tbl[8]  = '{1'b0, 1'b1, 3'd4, 32'd16};
    tbl[9]  = '{1'b0, 1'b1, 3'd4, 32'd16};
    tbl[10] = '{1'b1, 1'b1, 3'd4, 32'd16};
    tbl[11] = '{1'b1, 1'b1, 3'd3, 32'd16};
    tbl[12] = '{1'b1, 1'b1, 3'd2, 32'd20};
    tbl[13] = '{1'b1, 1'b1, 3'd2, 32'd24};

    // Streaming: first output on cycle 2, then one per cycle.
    do_reset();
    out_ready = 1'b1;
    fill(32'h0, 40);
    for (int c = 0; c < 20; c++) begin
      sample();
      if (c == 0) begin
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_pc", imem_pc, RESET_PC);
      end
      if (c == 1) chk("lat_valid_c1", 32'(out_valid), 32'd0);
      if (c == 2) begin
        chk("lat_valid_c2", 32'(out_valid), 32'd1);
        chk("lat_pc_c2", out_pc, 32'd0);
      end
      tick();
    end
    chk("throughput", 32'(hs_cnt), 32'd18);

    // Backpressure saturation and release.
    do_reset();
    fill(32'h0, 40);
    for (int i = 0; i < 14; i++) begin
      out_ready = tbl[i].rdy;
      sample();
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("bp_count_%0d", i), 32'(queue_count), 32'(tbl[i].cnt));
      chk($sformatf("bp_imem_pc_%0d", i), imem_pc, tbl[i].pc);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      sample();
      tick();
    end
    chk("bp_no_loss", 32'(hs_cnt), 32'd10);

    // Redirect with 3 queued entries and a read in flight.
    do_reset();
    fill(32'h0, 40);
    for (int i = 0; i < 4; i++) begin
      sample();
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    exp_q.delete();
    fill(32'h100, 20);
    hs_cnt = 0;
    sample();
    chk("rd_pre_count", 32'(queue_count), 32'd3);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    sample();
    chk("rd_count", 32'(queue_count), 32'd0);
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_imem_pc", imem_pc, 32'h100);
    tick();
    for (int i = 0; i < 8; i++) begin
      sample();
      tick();
    end
    chk("rd_stream", 32'(hs_cnt), 32'd7);

    // Stop on return of PC 0x20.
    do_reset();
    stop_en   = 1'b1;
    stop_pc   = 32'h20;
    out_ready = 1'b1;
    fill(32'h0, 8);
    begin
      int w;
      for (w = 0; w < 40; w++) begin
        sample();
        if (fetch_done) break;
        tick();
      end
      if (w == 40) begin
        nchecks++;
        nerr++;
        $display("FAIL stop_done_wait: got fetch_done=0 expected 1 within 40 cycles");
      end
    end
    chk("stop_count", 32'(queue_count), 32'd0);
    chk("stop_valid", 32'(out_valid), 32'd0);
    chk("stop_imem_pc", imem_pc, 32'h20);
    chk("stop_drained", 32'(exp_q.size()), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      tick();
    end
    chk("stop_outputs", 32'(hs_cnt), 32'd8);

    // Redirect out of HALT.
    stop_en        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    exp_q.delete();
    fill(32'h40, 10);
    sample();
    chk("halt_done", 32'(fetch_done), 32'd1);
    tick();
    redirect_valid = 1'b0;
    sample();
    chk("hr_done", 32'(fetch_done), 32'd0);
    chk("hr_imem_pc", imem_pc, 32'h40);
    chk("hr_valid_1", 32'(out_valid), 32'd0);
    tick();
    sample();
    chk("hr_valid_2", 32'(out_valid), 32'd0);
    tick();
    sample();
    chk("hr_valid_3", 32'(out_valid), 32'd1);
    chk("hr_pc_3", out_pc, 32'h40);
    tick();

    // Reset mid-stream with a full queue.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sample();
      tick();
    end
    sample();
    chk("mr_pre_count", 32'(queue_count), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    sample();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_count", 32'(queue_count), 32'd0);
    chk("mr_out_pc", out_pc, 32'd0);
    chk("mr_out_instr", out_instr, 32'd0);
    chk("mr_done", 32'(fetch_done), 32'd0);
    chk("mr_imem_pc", imem_pc, RESET_PC);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the instruction memory: drives its PC, tracks the one in-flight read, and buffers returned instructions in a small FIFO fetch queue toward decode.
- Handles decode backpressure through a valid/ready handshake.
- Handles redirects (branch/flush) and the memory's end-of-program stop indication.
- Sits between the instruction memory (1-cycle registered read) and the decode stage.

Parameters:
DEPTH, 4, fetch queue entries (power of 2, >=2)
RESET_PC, 32'h0, PC issued first after reset (word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_pc  output  32  PC presented to instruction memory (= pc_reg, combinational)
imem_instr  input  32  instruction returned; valid the cycle after issue
imem_stop  input  1  memory end-of-program flag, qualifies imem_instr
redirect_valid  input  1  flush queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0
out_valid  output  1  queue head valid
out_instr  output  32  queue head instruction
out_pc  output  32  PC of queue head instruction
out_ready  input  1  decode accepts head when out_valid && out_ready
queue_count  output  $clog2(DEPTH+1)  entries currently held
fetch_done  output  1  high in HALT with queue empty

Behaviour:
- Reset values:
  - pc_reg=RESET_PC, state=FETCH, inflight_v=0, queue empty.
  - out_valid=0, out_instr=0, out_pc=0, queue_count=0, fetch_done=0.
  - Reset mid-operation discards the queue and the in-flight read.
- States: FETCH (issuing), HALT (stop seen, no issue).
  - FETCH->HALT: inflight_v && imem_stop && !redirect_valid.
  - Any state->FETCH: redirect_valid.
- Issue in cycle t requires all of: state==FETCH, !redirect_valid, (queue_count + inflight_v) < DEPTH.
  - On issue: pc_reg<=pc_reg+4 (wraps modulo 2^32), inflight_v<=1, inflight_pc<=pc_reg.
  - No issue: inflight_v<=0, pc_reg holds.
- Return in cycle t+1 (inflight_v=1):
  - !imem_stop: push {imem_instr, inflight_pc} into the queue tail.
  - imem_stop: no push; enter HALT; any read issued in the same cycle is squashed (inflight_v<=0) and pc_reg rolls back to inflight_pc.
- Latency: issue->push 1 cycle; push->out_valid visible next cycle. After reset release: first issue cycle 0, push cycle 1, out_valid cycle 2.
- Throughput: 1 instr/cycle sustained when out_ready stays high.
- Dequeue: when out_valid && out_ready, pop the head; out_* show the next entry the following cycle.
- Simultaneous push and pop: queue_count unchanged; legal even at count==DEPTH-1 or 0.
- Overflow is impossible by the issue credit rule. A push when full is a design error; verification asserts it never happens.
- Redirect has highest priority:
  - At the edge: queue cleared, inflight_v<=0 (the returning instruction is dropped), pc_reg<=redirect_pc & ~3, state<=FETCH.
  - A pop in the same cycle is ignored (the head is discarded anyway).
  - The first issue from the new PC happens the cycle after the redirect.
- out_instr/out_pc hold their last values when out_valid=0; only contents under out_valid are checked.
- fetch_done = (state==HALT) && (queue_count==0), registered-free combinational from state.

Test Plan:
- Reset, memory returns instr = PC*16 (no stop), out_ready=1 -> out_valid rises cycle 2; out_pc sequence 0,4,8,... one per cycle; out_instr matches.
- out_ready=0 for 10 cycles -> queue_count saturates at 4; imem_pc stops advancing at 16; release -> entries PC 0,4,8,12 then 16 in order, no loss or duplicate.
- Redirect to 0x103 while queue holds 3 entries and a read is in flight -> next cycle queue_count=0, out_valid=0; next fetched out_pc=0x100; dropped PCs never appear.
- imem_stop asserted on return of PC 0x20 -> HALT; PC 0x20 and later never enqueued; fetch_done=1 once decode drains earlier entries.
- Redirect to 0x40 while in HALT with fetch_done=1 -> state FETCH, fetch_done=0, out_pc 0x40 appears 2 cycles later.
- rst asserted mid-stream with full queue -> next cycle all outputs at reset values, imem_pc=RESET_PC.
